// File: rtl/mult_share_arb_if.sv
// ---------------------------------------------------------------------------
// mult_share_arb_if
// Bundles the signals between the DSP clients, the shared arbiter and the
// single mult_pipe instance.
//   hold           : clients -> arbiter, stop accepting new requests
//   req_valid/a/b  : clients -> arbiter, per-requester operand pairs (packed)
//   req_ready      : arbiter -> clients, one-hot grant
//   mult_in_*      : arbiter -> multiplier, registered operands and strobe
//   mult_out_*     : multiplier -> arbiter, product and strobe
//   resp_*         : arbiter -> clients, tagged product return bus
//   busy           : arbiter -> clients, products still in flight
// Modports: slave = the arbiter's view, master = the environment's view.
// ---------------------------------------------------------------------------
interface mult_share_arb_if #(
  parameter int M    = 5,
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic                  hold;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*M-1:0]     req_a;
  logic [NREQ*N-1:0]     req_b;
  logic                  mult_in_valid;
  logic [M-1:0]          mult_in_a;
  logic [N-1:0]          mult_in_b;
  logic                  mult_out_valid;
  logic [M+N-1:0]        mult_out;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [M+N-1:0]        resp_data;
  logic                  busy;

  modport slave (
    input  hold, req_valid, req_a, req_b, mult_out_valid, mult_out,
    output req_ready, mult_in_valid, mult_in_a, mult_in_b,
           resp_valid, resp_id, resp_data, busy
  );

  modport master (
    output hold, req_valid, req_a, req_b, mult_out_valid, mult_out,
    input  req_ready, mult_in_valid, mult_in_a, mult_in_b,
           resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// ---------------------------------------------------------------------------
// mult_share_arb
// Shares one pipelined signed multiplier among NREQ requesters. A round-robin
// arbiter accepts at most one operand pair per cycle into a registered issue
// stage feeding the multiplier. A LAT-deep shadow pipeline carries the
// requester ID alongside each product so the result returns on the shared
// response bus labelled with its owner, LAT+2 cycles after acceptance.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset
//   bus      : mult_share_arb_if.slave (requests, grants, multiplier
//              interface, response bus, busy)
//   tag_err  : (only with MULT_SHARE_TAG_CHECK_EN) sticky flag raised when
//              the multiplier's output strobe disagrees with the tag pipeline
//
// Optional build macro: MULT_SHARE_TAG_CHECK_EN
//   undefined : no tag_err port, mult_out_valid is ignored entirely
//   defined   : adds tag_err and its comparison logic
// ---------------------------------------------------------------------------
module mult_share_arb #(
  parameter int M    = 5,
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef MULT_SHARE_TAG_CHECK_EN
  output logic tag_err,
`endif
  mult_share_arb_if.slave bus
);

  // Arbitration results (combinational)
  logic [NREQ-1:0]          grant_s;
  logic                     grant_vld_s;
  logic [IDW-1:0]           grant_id_s;
  int                       cand_s;
  logic [M-1:0]             win_a_s;
  logic [N-1:0]             win_b_s;

  // Round-robin pointer: first requester examined next cycle
  logic [IDW-1:0]           ptr_r;

  // Issue stage (drives the multiplier inputs)
  logic                     iss_vld_r;
  logic [IDW-1:0]           iss_id_r;
  logic [M-1:0]             in_a_r;
  logic [N-1:0]             in_b_r;

  // Tag shadow pipeline; stage LAT-1 lines up with mult_out_valid
  logic [LAT-1:0]           tag_vld_r;
  logic [LAT-1:0][IDW-1:0]  tag_id_r;

  // Response stage and busy flag
  logic                     resp_valid_r;
  logic [IDW-1:0]           resp_id_r;
  logic [M+N-1:0]           resp_data_r;
  logic                     busy_r;

  // Round-robin search starting at ptr_r, ascending with wrap-around
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    cand_s      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = int'(ptr_r) + k;
      if (cand_s >= NREQ) begin
        cand_s = cand_s - NREQ;
      end else begin
        cand_s = cand_s;
      end
      if (!bus.hold && !grant_vld_s && bus.req_valid[cand_s[IDW-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = cand_s[IDW-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (grant_vld_s) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign win_a_s = bus.req_a[grant_id_s*M +: M];
  assign win_b_s = bus.req_b[grant_id_s*N +: N];

  // Pointer advances past the winner; holds when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (grant_vld_s) begin
      ptr_r <= (grant_id_s == IDW'(NREQ-1)) ? '0 : grant_id_s + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Issue register: capture winner's operands, hold them when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_vld_r <= 1'b0;
      iss_id_r  <= '0;
      in_a_r    <= '0;
      in_b_r    <= '0;
    end else begin
      iss_vld_r <= grant_vld_s;
      if (grant_vld_s) begin
        iss_id_r <= grant_id_s;
        in_a_r   <= win_a_s;
        in_b_r   <= win_b_s;
      end else begin
        iss_id_r <= iss_id_r;
        in_a_r   <= in_a_r;
        in_b_r   <= in_b_r;
      end
    end
  end

  // Tag shadow pipeline shifting {valid, id} in step with the multiplier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_r <= '0;
      tag_id_r  <= '0;
    end else begin
      tag_vld_r[0] <= iss_vld_r;
      tag_id_r[0]  <= iss_id_r;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_id_r[s]  <= tag_id_r[s-1];
      end
    end
  end

  // Response register: the tag, not the multiplier strobe, qualifies the product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= '0;
    end else begin
      resp_valid_r <= tag_vld_r[LAT-1];
      if (tag_vld_r[LAT-1]) begin
        resp_id_r   <= tag_id_r[LAT-1];
        resp_data_r <= bus.mult_out;
      end else begin
        resp_id_r   <= resp_id_r;
        resp_data_r <= resp_data_r;
      end
    end
  end

  // busy is registered from the next-state of issue, tag and response
  // valids: next issue = grant, next tags = {tags, issue}, next resp = last tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= grant_vld_s | iss_vld_r | (|tag_vld_r);
    end
  end

`ifdef MULT_SHARE_TAG_CHECK_EN
  logic tag_err_r;

  // Sticky disagreement flag between multiplier strobe and tag pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_err_r <= 1'b0;
    end else if (bus.mult_out_valid != tag_vld_r[LAT-1]) begin
      tag_err_r <= 1'b1;
    end else begin
      tag_err_r <= tag_err_r;
    end
  end

  assign tag_err = tag_err_r;
`else
  // Multiplier strobe is intentionally unused in this build
  logic unused_mult_out_valid_s;
  assign unused_mult_out_valid_s = bus.mult_out_valid;
`endif

  assign bus.req_ready     = grant_s;
  assign bus.mult_in_valid = iss_vld_r;
  assign bus.mult_in_a     = in_a_r;
  assign bus.mult_in_b     = in_b_r;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_id       = resp_id_r;
  assign bus.resp_data     = resp_data_r;
  assign bus.busy          = busy_r;

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one pipelined signed multiplier (mult_pipe, valid-in/valid-out, fixed latency) among NREQ requesters.
- Round-robin arbiter accepts at most one operand pair per cycle and drives the registered multiplier inputs.
- A tag shadow pipeline tracks the requester ID of every product, so each result returns on a shared response bus labelled with its owner.
- Sits between several DSP clients and a single mult_pipe instance.

Parameters:
- M, 5, width of operand a (two's complement)
- N, 4, width of operand b (two's complement)
- NREQ, 4, number of requesters (2..16)
- LAT, 2, multiplier latency in cycles from mult_in_valid to mult_out_valid (>=1)
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- hold  in  1  1 = accept no new requests; in-flight products still drain
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester grant (combinational)
- req_a  in  NREQ*M  packed operand a; requester i at [i*M +: M]
- req_b  in  NREQ*N  packed operand b; requester i at [i*N +: N]
- mult_in_valid  out  1  to multiplier
- mult_in_a  out  M  to multiplier
- mult_in_b  out  N  to multiplier
- mult_out_valid  in  1  from multiplier
- mult_out  in  M+N  signed product from multiplier
- resp_valid  out  1  response strobe
- resp_id  out  IDW  owner of the response
- resp_data  out  M+N  signed product
- busy  out  1  1 while any accepted request has not yet produced its response

Behaviour:
- Reset (rst low, asynchronous): all outputs registered to 0, including mult_in_*, resp_* and busy; RR pointer = 0; tag pipeline cleared. Reset mid-operation discards in-flight tags. Any later mult_out_valid leftovers from the multiplier are ignored, because the tag stage is invalid.
- Arbitration: req_ready = one-hot grant, or all zeros when hold=1 or no req_valid is set.
  - Search starts at the RR pointer and ascends with wrap-around; the first asserted req_valid wins.
  - After a grant to requester i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. A requester must hold a/b stable while valid and not ready.
- Issue: on a transfer in cycle T, mult_in_valid=1 with mult_in_a/b = the winner's operands at T+1; otherwise mult_in_valid=0 and the operands hold.
- Tag pipeline: LAT-stage shift register of {valid, id}, loaded from the issue register. Stage LAT-1 aligns with mult_out_valid.
- Response: when the tag's last stage is valid, then in the next cycle resp_valid=1, resp_id=tag id, resp_data=mult_out registered.
  - Total latency from accept in cycle T to response: T+LAT+2.
  - No response back-pressure; one response per cycle maximum, giving full throughput of 1/cycle.
- busy = OR of the issue valid, all tag-stage valids and the response stage.
- hold toggled mid-stream: only new grants are affected; the pipeline continues.
- Single requester with valid held high: granted every cycle (pointer wraps back to it).

Optional Feature:
- MULT_SHARE_TAG_CHECK_EN defined: adds output port tag_err (1 bit, reset 0). tag_err is sticky and set when mult_out_valid differs from the tag last-stage valid in any cycle; cleared only by reset. Responses are still driven from the tag pipeline.
- Not defined: no tag_err port and no comparison logic; mult_out_valid is ignored.

Test Plan:
- Requester 0 only, a=12, b=3, after reset release: mult_in_valid 1 cycle after accept; resp_valid at accept+LAT+2 with resp_id=0, resp_data=9'h024 (36); busy then falls.
- Signed products:
  - requester 2 sends (-12,3): expect 9'h1DC (-36), id 2.
  - requester 2 sends (-12,-3): expect 9'h024.
  - requester 2 sends (-15,-7): expect 9'h069 (105).
  - requester 2 sends (15,-8): expect 9'h188 (-120).
- All 4 requesters valid continuously with distinct operands (3x7=21, 5x2=10, -4x4=-16, 1x-1=-1): grants in order 0,1,2,3,0,...; responses back-to-back in the same order with correct ids and data.
- hold=1 while req_valid=4'b1111: req_ready stays 0 and no mult_in_valid. Releasing hold resumes grants from the saved pointer.
- Assert rst low with 2 products in flight: all outputs 0 immediately; no stale resp_valid after release.
- With MULT_SHARE_TAG_CHECK_EN, force a spurious mult_out_valid pulse: tag_err rises next cycle and stays 1 until reset.
